data_packer_param: RTL

Parametrised narrow-to-wide data packer. It gathers RATIO input beats of IN_W bits into one OUT_W = IN_W*RATIO word. Over the fixed 2-to-8 consolidation it adds valid/ready backpressure on both sides, selectable pack order, early flush of partial words on din_last with per-slot keep, a synchronous clear and a word counter. It sits between serial front-end capture logic and wide datapath consumers.

---
 rtl/data_pack_pkg.sv | 19 +
 rtl/data_packer_param_pack_out_reg.sv | 56 +++++
 rtl/data_packer_param.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/data_pack_pkg.sv
// data_pack_pkg
//   Shared definitions for the narrow-to-wide data packer.
//   - PACK_MSB_FIRST / PACK_LSB_FIRST : pack-order selectors
//   - slot_index()                    : slot that beat number `cnt` lands in
package data_pack_pkg;

    localparam bit PACK_MSB_FIRST = 1'b1;
    localparam bit PACK_LSB_FIRST = 1'b0;

    // MSB-first fills from the top slot downward; LSB-first fills from slot 0 upward.
    function automatic int unsigned slot_index(
        input int unsigned cnt,
        input int unsigned ratio,
        input bit          order
    );
        return (order == PACK_MSB_FIRST) ? (ratio - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/data_packer_param_pack_out_reg.sv
// pack_out_reg
//   Output holding register of the data packer: valid/ready handshake,
//   packed data, per-slot keep and packet-last flag.
//   Ports:
//     clk, rstn        clock / asynchronous active-low reset
//     clr              synchronous clear of valid and last
//     load             capture load_data/load_keep/load_last (only when free)
//     load_data/keep/last  word presented for capture
//     dout, dout_keep, dout_last, dout_vld  registered output word
//     dout_rdy         downstream ready
//     free             register can take a new word this cycle
module pack_out_reg
    import data_pack_pkg::*;
#(
    parameter int unsigned OUT_W = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [OUT_W-1:0] load_data,
    input  logic [RATIO-1:0] load_keep,
    input  logic             load_last,
    output logic [OUT_W-1:0] dout,
    output logic [RATIO-1:0] dout_keep,
    output logic             dout_vld,
    output logic             dout_last,
    input  logic             dout_rdy,
    output logic             free
);

    assign free = !dout_vld || dout_rdy;

    // Data fields are left untouched when the word is consumed or cleared;
    // only valid (and last on clear) drop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout      <= '0;
            dout_keep <= '0;
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
        end else if (clr) begin
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
        end else if (load) begin
            dout      <= load_data;
            dout_keep <= load_keep;
            dout_last <= load_last;
            dout_vld  <= 1'b1;
        end else if (dout_rdy) begin
            dout_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/data_packer_param.sv
// data_packer_param
//   Gathers RATIO beats of IN_W bits into one IN_W*RATIO-bit word with
//   valid/ready on both sides, selectable pack order, early flush on
//   din_last (unfilled slots zero, keep cleared), synchronous clear and a
//   saturating count of words transferred out.
//   Ports:
//     clk, rstn                  clock / asynchronous active-low reset
//     clr                        synchronous clear (partial, pending, output word)
//     din, din_vld, din_last     input beat stream
//     din_rdy                    registered input ready (low while a word is pending)
//     dout, dout_keep, dout_vld, dout_last   packed output word
//     dout_rdy                   downstream ready
//     word_cnt                   words transferred out, saturating
module data_packer_param
    import data_pack_pkg::*;
#(
    parameter int unsigned IN_W      = 2,
    parameter int unsigned RATIO     = 4,
    parameter bit          MSB_FIRST = PACK_MSB_FIRST,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic [IN_W-1:0]       din,
    input  logic                  din_vld,
    input  logic                  din_last,
    output logic                  din_rdy,
    output logic [IN_W*RATIO-1:0] dout,
    output logic [RATIO-1:0]      dout_keep,
    output logic                  dout_vld,
    output logic                  dout_last,
    input  logic                  dout_rdy,
    output logic [CNT_W-1:0]      word_cnt
);

    localparam int unsigned OUT_W  = IN_W * RATIO;
    localparam int unsigned SLOT_W = $clog2(RATIO);

    logic [SLOT_W-1:0] cnt;
    logic [OUT_W-1:0]  acc;
    logic [RATIO-1:0]  keep;
    logic              pend;
    logic              pend_last;

    logic              accept;
    logic              complete;
    int unsigned       slot;
    logic [OUT_W-1:0]  acc_upd;
    logic [RATIO-1:0]  keep_upd;
    logic              free;
    logic              load;
    logic [OUT_W-1:0]  load_data;
    logic [RATIO-1:0]  load_keep;
    logic              load_last;

    always_comb begin
        accept   = din_vld && din_rdy;
        slot     = slot_index(32'(cnt), RATIO, MSB_FIRST);
        acc_upd  = acc;
        keep_upd = keep;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (slot == i) begin
                acc_upd[i*IN_W +: IN_W] = din;
                keep_upd[i]             = 1'b1;
            end
        end
        complete = accept && ((cnt == SLOT_W'(RATIO - 1)) || din_last);

        // A pending word always goes first; no beat is accepted while pending.
        load      = !clr && free && (pend || complete);
        load_data = pend ? acc       : acc_upd;
        load_keep = pend ? keep      : keep_upd;
        load_last = pend ? pend_last : din_last;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            acc       <= '0;
            keep      <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            din_rdy   <= 1'b1;
        end else if (clr) begin
            cnt       <= '0;
            acc       <= '0;
            keep      <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            din_rdy   <= 1'b1;
        end else if (pend) begin
            if (free) begin
                acc     <= '0;
                keep    <= '0;
                pend    <= 1'b0;
                din_rdy <= 1'b1;
            end
        end else if (accept) begin
            if (complete) begin
                cnt <= '0;
                if (free) begin
                    acc  <= '0;
                    keep <= '0;
                end else begin
                    // Output busy: park the finished word in the accumulator.
                    acc       <= acc_upd;
                    keep      <= keep_upd;
                    pend      <= 1'b1;
                    pend_last <= din_last;
                    din_rdy   <= 1'b0;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                acc  <= acc_upd;
                keep <= keep_upd;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_cnt <= '0;
        end else if (dout_vld && dout_rdy && !(&word_cnt)) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    pack_out_reg #(
        .OUT_W(OUT_W),
        .RATIO(RATIO)
    ) u_out (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (load_last),
        .dout      (dout),
        .dout_keep (dout_keep),
        .dout_vld  (dout_vld),
        .dout_last (dout_last),
        .dout_rdy  (dout_rdy),
        .free      (free)
    );

endmodule
